pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register for the SELEN CPU. It replaces the fixed per-stage register blocks with one configurable element carrying a WIDTH-bit payload between two pipeline stages. It uses a valid/ready handshake and an optional two-entry skid buffer. It supports synchronous flush, a hold (stall) input, and bubble insertion that zeroes a parameter-selected set of control bits such as register and memory write enables.

## Interface
Parameters:
- WIDTH, 128: payload width in bits (≥1).
- KILL_MASK, {WIDTH{1'b0}}: WIDTH-bit mask; bits set to 1 are forced to 0 on out_data while bubble is high.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of all held entries.
- stall  in  1  hold: no accept, no pop, contents frozen.
- bubble  in  1  present a NOP downstream; contents retained.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry presented downstream.
- out_ready  in  1  downstream consumes head.
- out_data  out  WIDTH  head payload, masked per bubble.
- occupancy  out  2  number of held entries (0..2).

## Operation
- accept = in_valid & in_ready & ~flush & ~stall.
- pop = out_valid & out_ready & ~flush.
- out_valid = (occupancy != 0) & ~stall & ~bubble.
- out_data:
  - head entry when occupancy != 0, else all zeros;
  - ANDed with ~KILL_MASK while bubble = 1.
- Flush priority: flush > stall > accept/pop.
  - Flush empties the stage on the next edge (occupancy=0, entries zeroed).
  - In_data presented in the same cycle is dropped.
- State machine (skid build) over EMPTY / ONE / TWO:
  - EMPTY: accept → ONE.
  - ONE: accept & pop → ONE (head replaced); accept & ~pop → TWO; pop & ~accept → EMPTY; otherwise hold.
  - TWO: pop → ONE (second entry becomes head); accept cannot occur.
  - Any state: flush → EMPTY.
- FIFO order strictly preserved; no payload duplicated or lost except on flush.
- Bubble and stall never modify stored entries or occupancy.

## Timing
- Reset values:
  - out_valid=0, occupancy=0, out_data=0, all entries=0;
  - in_ready=1 once rst deasserts (0 while rst is asserted).
- Latency: payload accepted at edge N is on out_data with out_valid=1 in cycle N+1 (if not stalled, bubbled or flushed).
- Throughput: 1 transfer/cycle sustained when out_ready=1.
- in_ready (skid build) is registered: in_ready = (state != TWO) & ~stall. It has no combinational path from out_ready.
- Simultaneous accept and pop in ONE: occupancy stays 1; the new head is visible the next cycle.
- Reset asserted mid-transfer: state → EMPTY immediately (asynchronous); the in-flight payload is lost.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer as above; in_ready is registered; occupancy ranges 0..2.
- PIPE_STAGE_SKID_EN undefined: single entry; TWO is unreachable; occupancy ranges 0..1.
  - in_ready = ~stall & (occupancy==0 | (out_ready & ~bubble)), combinational.
  - Accept and pop in the same cycle replace the entry.
  - All other behaviour is identical.

## Test plan
- Reset: hold rst=1 for 3 cycles with in_valid=1 → out_valid=0, occupancy=0, out_data=0; after release in_ready=1.
- Streaming: WIDTH=8, send 0x01..0x10 back-to-back with out_ready=1 → 0x01..0x10 in order, one per cycle, first at edge+1.
- Backpressure (skid): out_ready=0 while sending 0xA1,0xA2,0xA3 → occupancy reaches 2, in_ready=0, 0xA3 not accepted. Raise out_ready → 0xA1 then 0xA2 delivered, then 0xA3 accepted.
- Bubble: KILL_MASK=8'h81, head=0xFF, bubble=1 → out_valid=0, out_data=0x7E, occupancy unchanged. Drop bubble → 0xFF delivered.
- Flush: occupancy=2 with flush=1 and in_valid=1 (0x55) in the same cycle → next cycle occupancy=0, out_valid=0, and 0x55 never appears.
- Stall: stall=1 for 4 cycles with occupancy=1 (0x3C) → out_valid=0, in_ready=0, contents kept. Release → 0x3C delivered once.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush, stall and bubble masking.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer; otherwise a single entry is held.
module pipe_stage_reg #(
    parameter int unsigned           WIDTH     = 128,
    parameter logic [WIDTH-1:0]      KILL_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             bubble,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] tail_next;
    logic             accept;
    logic             pop;

    assign occupancy = 2'(state);
    assign out_valid = (state != EMPTY) & ~stall & ~bubble;
    assign out_data  = ((state != EMPTY) ? head : '0) & (bubble ? ~KILL_MASK : '1);

`ifdef PIPE_STAGE_SKID_EN
    // Depends only on the state register and stall, never on out_ready.
    assign in_ready = ~rst & (state != TWO) & ~stall;
`else
    assign in_ready = ~rst & ~stall & ((state == EMPTY) | (out_ready & ~bubble));
`endif

    assign accept = in_valid & in_ready & ~flush & ~stall;
    assign pop    = out_valid & out_ready & ~flush;

    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        if (flush) begin
            state_next = EMPTY;
            head_next  = '0;
            tail_next  = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        head_next  = in_data;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_next = in_data;
                    end else if (accept) begin
`ifdef PIPE_STAGE_SKID_EN
                        state_next = TWO;
                        tail_next  = in_data;
`else
                        head_next  = in_data;
`endif
                    end else if (pop) begin
                        state_next = EMPTY;
                        head_next  = '0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_next = ONE;
                        head_next  = tail;
                        tail_next  = '0;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    head_next  = '0;
                    tail_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int unsigned W  = 8;
    localparam logic [7:0]  KM = 8'h81;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       stall = 1'b0;
    logic       bubble = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [1:0] occupancy;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];

    pipe_stage_reg #(
        .WIDTH    (W),
        .KILL_MASK(KM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .stall    (stall),
        .bubble   (bubble),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl, st, bu, iv;
        logic [7:0] id;
        logic       ordy;
        logic       ov;
        logic       rdy_chk;
        logic       rdy;
        logic [7:0] od;
        logic [1:0] occ;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, compare against the queue model, clock, update the model.
    task automatic step(input string tag, input logic fl, input logic st, input logic bu,
                        input logic iv, input logic [7:0] id, input logic ordy);
        logic       e_rdy, e_ov;
        logic [7:0] e_data;
        flush = fl; stall = st; bubble = bu; in_valid = iv; in_data = id; out_ready = ordy;
        #2;
        e_ov   = (q.size() != 0) && !st && !bu;
        e_data = (q.size() != 0) ? q[0] : 8'h00;
        if (bu) e_data = e_data & ~KM;
`ifdef PIPE_STAGE_SKID_EN
        e_rdy = !st && (q.size() < 2);
`else
        e_rdy = !st && ((q.size() == 0) || (ordy && !bu));
`endif
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({tag, ".out_data"},  32'(out_data),  32'(e_data));
        chk({tag, ".occupancy"}, 32'(occupancy), 32'(q.size()));
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (e_ov && ordy) void'(q.pop_front());
            if (iv && e_rdy) q.push_back(id);
        end
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        //           fl   st   bu   iv   id     ordy ov   rchk rdy  od     occ
        tbl[0] = '{1'b0,1'b0,1'b0,1'b1,8'hFF,1'b0,1'b0,1'b1,1'b1,8'h00,2'd0};
        tbl[1] = '{1'b0,1'b0,1'b1,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,8'h7E,2'd1};
        tbl[2] = '{1'b0,1'b1,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,8'hFF,2'd1};
        tbl[3] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b1,8'hFF,2'd1};
        tbl[4] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b1,8'h00,2'd0};
        tbl[5] = '{1'b0,1'b0,1'b0,1'b1,8'h3C,1'b1,1'b0,1'b1,1'b1,8'h00,2'd0};
        tbl[6] = '{1'b0,1'b0,1'b0,1'b1,8'h5A,1'b1,1'b1,1'b1,1'b1,8'h3C,2'd1};
        tbl[7] = '{1'b1,1'b0,1'b0,1'b1,8'h55,1'b1,1'b1,1'b1,1'b1,8'h5A,2'd1};
        tbl[8] = '{1'b0,1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b1,8'h00,2'd0};

        // Reset held for three cycles with traffic offered.
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset.in_ready",  32'(in_ready),  32'd0);
            chk("reset.out_valid", 32'(out_valid), 32'd0);
            chk("reset.occupancy", 32'(occupancy), 32'd0);
            chk("reset.out_data",  32'(out_data),  32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        q.delete();
        #1;
        chk("reset.release_ready", 32'(in_ready), 32'd1);

        // Table vectors: bubble masking, stall, replace-on-pop, flush dropping input.
        for (int i = 0; i < 9; i++) begin
            flush = tbl[i].fl; stall = tbl[i].st; bubble = tbl[i].bu;
            in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d.out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            if (tbl[i].rdy_chk) chk($sformatf("tbl%0d.in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d.out_data", i),  32'(out_data),  32'(tbl[i].od));
            chk($sformatf("tbl%0d.occupancy", i), 32'(occupancy), 32'(tbl[i].occ));
            step($sformatf("tbl%0d", i), tbl[i].fl, tbl[i].st, tbl[i].bu, tbl[i].iv, tbl[i].id, tbl[i].ordy);
        end

        // Back-to-back streaming 0x01..0x10.
        for (int i = 1; i <= 16; i++) step("stream", 1'b0, 1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
        idle("stream_drain", 3);

        // Stall for four cycles with one entry held.
        step("stall_load", 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) step("stall_hold", 1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
        chk("stall.kept", 32'(out_data), 32'h3C);
        step("stall_release", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        idle("stall_after", 2);

`ifdef PIPE_STAGE_SKID_EN
        // Backpressure fills both entries and blocks a third.
        step("bp_a1", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0);
        step("bp_a2", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b0);
        step("bp_a3", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
        chk("bp.occupancy_full", 32'(occupancy), 32'd2);
        for (int i = 0; i < 3; i++) step("bp_drain", 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1);
        idle("bp_idle", 2);

        // Flush with two entries held and new input offered.
        step("fl_b1", 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1, 1'b0);
        step("fl_b2", 1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0);
        step("fl_go", 1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        chk("flush.occupancy", 32'(occupancy), 32'd0);
        idle("fl_after", 3);
`endif

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 ($urandom % 16) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                 ($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
        end

        // Asynchronous reset in the middle of a transfer.
        step("arst_load", 1'b0, 1'b0, 1'b0, 1'b1, 8'hC7, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.occupancy", 32'(occupancy), 32'd0);
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.out_data",  32'(out_data),  32'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        idle("arst_after", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
